// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcodes,
// ALU/mux select values and the bundled datapath control word.
package mc_pkg;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_MEMADR = 4'd3;
  localparam logic [3:0] ST_MEMRD  = 4'd4;
  localparam logic [3:0] ST_MEMWB  = 4'd5;
  localparam logic [3:0] ST_MEMWR  = 4'd6;
  localparam logic [3:0] ST_EXEC   = 4'd7;
  localparam logic [3:0] ST_ALUWB  = 4'd8;
  localparam logic [3:0] ST_BRANCH = 4'd9;
  localparam logic [3:0] ST_JUMP   = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_timeout;
  } ctrl_t;

  function automatic logic is_mem_state(input logic [3:0] s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts stalled cycles, flags expiry combinationally
// when the count reaches TIMEOUT_CYCLES while still waiting (0 = never expires).
module mc_wait_timer
  import mc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (waiting) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && waiting && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM (R-type, lw, sw, beq; j when JUMP_EN is defined).
// Controls decode from the state register; memory states stall on mem_ready and abandon after TIMEOUT_CYCLES.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  logic [3:0] state_q, state_d;
  logic       is_sw_q, is_sw_d;
  logic       in_mem, waiting, clear, expired, op_legal;
  ctrl_t      ctl;

  assign in_mem  = is_mem_state(state_q);
  assign waiting = in_mem && !mem_ready;
  // A retried or abandoned access starts its next wait from zero.
  assign clear   = !in_mem || mem_ready || expired;

  mc_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .waiting(waiting),
    .expired(expired)
  );

  always_comb begin
    op_legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
`ifdef JUMP_EN
    op_legal = op_legal || (op == OP_J);
`endif
  end

  always_comb begin
    state_d = state_q;
    is_sw_d = is_sw_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)    state_d = ST_DECODE;
        else if (expired) state_d = ST_FETCH;
      end
      ST_DECODE: begin
        is_sw_d = (op == OP_SW);
        case (op)
          OP_RTYPE:     state_d = ST_EXEC;
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_BEQ:       state_d = ST_BRANCH;
`ifdef JUMP_EN
          OP_J:         state_d = ST_JUMP;
`endif
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = is_sw_q ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD: begin
        if (mem_ready)    state_d = ST_MEMWB;
        else if (expired) state_d = ST_FETCH;
      end
      ST_MEMWB:  state_d = ST_FETCH;
      ST_MEMWR: begin
        if (mem_ready || expired) state_d = ST_FETCH;
      end
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ALUWB:  state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
`ifdef JUMP_EN
      ST_JUMP:   state_d = ST_FETCH;
`endif
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state_q)
      ST_FETCH: begin
        ctl.mem_read    = 1'b1;
        ctl.alu_src_b   = SRCB_FOUR;
        ctl.alu_op      = ALU_ADD;
        ctl.pc_source   = PCSRC_ALU;
        ctl.ir_write    = mem_ready;
        ctl.pc_write    = mem_ready;
        ctl.mem_timeout = expired;
      end
      ST_DECODE: begin
        ctl.alu_src_b  = SRCB_IMM_SH2;
        ctl.alu_op     = ALU_ADD;
        ctl.illegal_op = !op_legal;
      end
      ST_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
      end
      ST_MEMRD: begin
        ctl.mem_read    = 1'b1;
        ctl.i_or_d      = 1'b1;
        ctl.mem_timeout = expired;
      end
      ST_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        ctl.mem_write   = 1'b1;
        ctl.i_or_d      = 1'b1;
        ctl.mem_timeout = expired;
      end
      ST_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REG;
        ctl.alu_op    = ALU_FUNCT;
      end
      ST_ALUWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SRCB_REG;
        ctl.alu_op        = ALU_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCSRC_ALUOUT;
      end
`ifdef JUMP_EN
      ST_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCSRC_JUMP;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  assign pc_write      = ctl.pc_write;
  assign pc_write_cond = ctl.pc_write_cond;
  assign i_or_d        = ctl.i_or_d;
  assign mem_read      = ctl.mem_read;
  assign mem_write     = ctl.mem_write;
  assign ir_write      = ctl.ir_write;
  assign mem_to_reg    = ctl.mem_to_reg;
  assign reg_dst       = ctl.reg_dst;
  assign reg_write     = ctl.reg_write;
  assign alu_src_a     = ctl.alu_src_a;
  assign alu_src_b     = ctl.alu_src_b;
  assign alu_op        = ctl.alu_op;
  assign pc_source     = ctl.pc_source;
  assign illegal_op    = ctl.illegal_op;
  assign mem_timeout   = ctl.mem_timeout;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: instruction-level model expands each instruction into its expected
// per-cycle state/control stream; a negedge process compares the DUT against it.
module tb_multicycle_control;

  localparam int TMO = 4;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                         S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
                         S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10;

  localparam logic [5:0] OPC_R = 6'b000000, OPC_LW = 6'b100011, OPC_SW = 6'b101011,
                         OPC_BEQ = 6'b000100, OPC_J = 6'b000010, OPC_BAD = 6'b001000,
                         OPC_JUNK = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_timeout;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  multicycle_control #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic illegal_op, mem_timeout;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    ctl_t       ctl;
  } exp_t;

  ctl_t act_ctl;
  assign act_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, illegal_op, mem_timeout};

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  int   n_cyc = 0;

  function automatic logic supported(input logic [5:0] o);
    logic s;
    s = (o == OPC_R) || (o == OPC_LW) || (o == OPC_SW) || (o == OPC_BEQ);
`ifdef JUMP_EN
    s = s || (o == OPC_J);
`endif
    return s;
  endfunction

  // Control word each step must show, written straight from the per-state table.
  function automatic ctl_t model_ctl(input logic [3:0] st, input logic rdy,
                                     input logic [5:0] o, input logic tmo);
    ctl_t c;
    c = '0;
    case (st)
      S_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy;
                      c.pc_write = rdy; c.mem_timeout = tmo; end
      S_DECODE: begin c.alu_src_b = 2'b11; c.illegal_op = !supported(o); end
      S_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      S_MEMRD:  begin c.mem_read = 1; c.i_or_d = 1; c.mem_timeout = tmo; end
      S_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      S_MEMWR:  begin c.mem_write = 1; c.i_or_d = 1; c.mem_timeout = tmo; end
      S_EXEC:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      S_ALUWB:  begin c.reg_write = 1; c.reg_dst = 1; end
      S_BRANCH: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                      c.pc_source = 2'b01; end
      S_JUMP:   begin c.pc_write = 1; c.pc_source = 2'b10; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic drive(input logic [3:0] st, input logic rdy, input logic [5:0] o,
                       input logic tmo);
    exp_t e;
    op        = o;
    mem_ready = rdy;
    e.st      = st;
    e.ctl     = model_ctl(st, rdy, o, tmo);
    expq.push_back(e);
    n_cyc++;
  endtask

  task automatic step(input logic [3:0] st, input logic rdy, input logic [5:0] o,
                      input logic tmo);
    @(posedge clk);
    #1;
    drive(st, rdy, o, tmo);
  endtask

  // Memory step: `waits` stalled cycles, then ready; the stall whose index equals TMO expires.
  task automatic mem_phase(input logic [3:0] st, input int waits, output bit timed_out);
    logic r, t;
    timed_out = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      r = (i == waits);
      t = !r && (TMO != 0) && (i == TMO);
      step(st, r, OPC_JUNK, t);
      if (t) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input int fw, input int mw);
    bit to;
    n_cyc = 0;
    mem_phase(S_FETCH, fw, to);
    if (to) return;
    step(S_DECODE, 1'b1, o, 1'b0);
    if (o == OPC_R) begin
      step(S_EXEC, 1'b1, OPC_JUNK, 1'b0);
      step(S_ALUWB, 1'b1, OPC_JUNK, 1'b0);
    end else if (o == OPC_LW) begin
      step(S_MEMADR, 1'b1, OPC_SW, 1'b0);
      mem_phase(S_MEMRD, mw, to);
      if (!to) step(S_MEMWB, 1'b1, OPC_JUNK, 1'b0);
    end else if (o == OPC_SW) begin
      step(S_MEMADR, 1'b1, OPC_LW, 1'b0);
      mem_phase(S_MEMWR, mw, to);
    end else if (o == OPC_BEQ) begin
      step(S_BRANCH, 1'b1, OPC_JUNK, 1'b0);
`ifdef JUMP_EN
    end else if (o == OPC_J) begin
      step(S_JUMP, 1'b1, OPC_JUNK, 1'b0);
`endif
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        tests++;
        if (state !== e.st || act_ctl !== e.ctl) begin
          fails++;
          $display("FAIL cycle_check t=%0t: state=%0d ctl=%h, expected state=%0d ctl=%h",
                   $time, state, act_ctl, e.st, e.ctl);
        end
      end
    end
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctl", 32'(act_ctl), 32'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(S_IDLE, 1'b0, OPC_JUNK, 1'b0);

    run_instr(OPC_R, 0, 0);    check("len_rtype", n_cyc, 4);
    run_instr(OPC_LW, 0, 0);   check("len_lw", n_cyc, 5);
    run_instr(OPC_LW, 0, 3);   check("len_lw_wait3", n_cyc, 8);
    run_instr(OPC_SW, 0, 0);   check("len_sw", n_cyc, 4);
    run_instr(OPC_SW, 0, 100); check("len_sw_timeout", n_cyc, 8);
    run_instr(OPC_BEQ, 0, 0);  check("len_beq", n_cyc, 3);
    run_instr(OPC_J, 0, 0);
`ifdef JUMP_EN
    check("len_j", n_cyc, 3);
`else
    check("len_j_illegal", n_cyc, 2);
`endif
    run_instr(OPC_BAD, 0, 0);  check("len_illegal", n_cyc, 2);
    run_instr(OPC_R, 4, 0);    check("len_fetch_ready_at_limit", n_cyc, 8);
    run_instr(OPC_LW, 5, 0);   check("len_fetch_timeout", n_cyc, 5);
    run_instr(OPC_LW, 2, 1);   check("len_lw_mixed_waits", n_cyc, 8);

    // Reset lands in the middle of a stalled store.
    step(S_FETCH, 1'b1, OPC_JUNK, 1'b0);
    step(S_DECODE, 1'b1, OPC_SW, 1'b0);
    step(S_MEMADR, 1'b1, OPC_JUNK, 1'b0);
    step(S_MEMWR, 1'b0, OPC_JUNK, 1'b0);
    @(negedge clk);
    check("memwr_before_reset", 32'(mem_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mem_write_async_drop", 32'(mem_write), 32'd0);
    check("state_async_idle", 32'(state), 32'd0);
    check("ctl_async_zero", 32'(act_ctl), 32'd0);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(S_IDLE, 1'b0, OPC_JUNK, 1'b0);
    @(negedge clk);
    check("idle_after_release", 32'(state), 32'd0);
    run_instr(OPC_R, 0, 0);    check("len_rtype_after_reset", n_cyc, 4);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
